// File: rtl/rf_ckpt_ctrl.sv
// Checkpoint manager for a register file with a whole-file replace port.
// Optional protocol checking is enabled with `define NCPU_CKPT_CHECK_EN.
module rf_ckpt_ctrl #(
  parameter int DW        = 6,
  parameter int AW        = 5,
  parameter int NUM_WRITE = 2,
  parameter int NUM_CKPT  = 4,
  parameter int CW        = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DW*(1<<AW)-1:0]   RF_DO,
  input  logic [NUM_WRITE-1:0]    RF_WE,
  input  logic [AW*NUM_WRITE-1:0] RF_WADDR,
  input  logic [DW*NUM_WRITE-1:0] RF_WDATA,
  input  logic                    ALLOC_VALID,
  output logic                    ALLOC_READY,
  output logic [CW-1:0]           ALLOC_ID,
  input  logic                    FREE,
  input  logic                    RECOVER,
  input  logic [CW-1:0]           RECOVER_ID,
  output logic                    RF_REP,
  output logic [DW*(1<<AW)-1:0]   RF_DI,
  output logic [CW:0]             COUNT,
  output logic                    ERR
);

  localparam int NE = 1 << AW;
  localparam int FW = DW * NE;
  localparam logic [CW:0] FULL_C = (CW+1)'(NUM_CKPT);

  logic [FW-1:0] slot_r [NUM_CKPT];
  logic [CW-1:0] head_r;
  logic [CW-1:0] tail_r;
  logic [CW:0]   count_r;
  logic          rep_r;
  logic [FW-1:0] di_r;
  logic          err_r;

  logic [FW-1:0] snap_s;
  logic          free_ok_s;
  logic [CW-1:0] head_n_s;
  logic [CW:0]   count_f_s;
  logic [CW-1:0] dist_s;
  logic          rec_ok_s;
  logic          alloc_ready_s;
  logic          alloc_ok_s;
  logic          err_set_s;
  logic [CW-1:0] tail_nx_s;
  logic [CW:0]   count_nx_s;

  // Head and count as seen after any same-cycle free; recover is judged against these.
  assign free_ok_s     = FREE & (count_r != {(CW+1){1'b0}});
  assign head_n_s      = head_r + CW'(free_ok_s);
  assign count_f_s     = count_r - (CW+1)'(free_ok_s);
  assign dist_s        = RECOVER_ID - head_n_s;
  assign alloc_ready_s = (count_r != FULL_C) & ~rep_r;
  assign alloc_ok_s    = ALLOC_VALID & alloc_ready_s & ~RECOVER;

`ifdef NCPU_CKPT_CHECK_EN
  logic live_s;
  assign live_s    = ({1'b0, dist_s} < count_f_s);
  assign rec_ok_s  = RECOVER & live_s;
  assign err_set_s = (ALLOC_VALID & ~alloc_ready_s)
                   | (FREE & (count_r == {(CW+1){1'b0}}))
                   | (RECOVER & ~live_s);
`else
  assign rec_ok_s  = RECOVER;
  assign err_set_s = 1'b0;
`endif

  // Snapshot = file contents after this edge; later ports override earlier ones.
  always_comb begin
    snap_s = RF_DO;
    for (int p = 0; p < NUM_WRITE; p++) begin
      for (int e = 0; e < NE; e++) begin
        if (RF_WE[p] && (RF_WADDR[p*AW +: AW] == AW'(e))) begin
          snap_s[e*DW +: DW] = RF_WDATA[p*DW +: DW];
        end else begin
          snap_s[e*DW +: DW] = snap_s[e*DW +: DW];
        end
      end
    end
  end

  // Next tail and count; a recover truncates the buffer at the restored slot.
  always_comb begin
    tail_nx_s  = tail_r;
    count_nx_s = count_r;
    if (rec_ok_s) begin
      tail_nx_s  = RECOVER_ID;
      count_nx_s = {1'b0, dist_s};
    end else begin
      tail_nx_s  = tail_r + CW'(alloc_ok_s);
      count_nx_s = count_f_s + (CW+1)'(alloc_ok_s);
    end
  end

  // Pointer, count, replace and error registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_r  <= {CW{1'b0}};
      tail_r  <= {CW{1'b0}};
      count_r <= {(CW+1){1'b0}};
      rep_r   <= 1'b0;
      di_r    <= {FW{1'b0}};
      err_r   <= 1'b0;
    end else begin
      head_r  <= head_n_s;
      tail_r  <= tail_nx_s;
      count_r <= count_nx_s;
      rep_r   <= rec_ok_s;
      err_r   <= err_r | err_set_s;
      if (rec_ok_s) begin
        di_r <= slot_r[RECOVER_ID];
      end else begin
        di_r <= di_r;
      end
    end
  end

  // Snapshot storage carries no reset; only allocated slots are ever read.
  always_ff @(posedge CLK) begin
    if (alloc_ok_s) begin
      slot_r[tail_r] <= snap_s;
    end else begin
      slot_r[tail_r] <= slot_r[tail_r];
    end
  end

  assign ALLOC_READY = alloc_ready_s;
  assign ALLOC_ID    = tail_r;
  assign RF_REP      = rep_r;
  assign RF_DI       = di_r;
  assign COUNT       = count_r;
  assign ERR         = err_r;

endmodule
